// File: rtl/rv_decode_pkg.sv
// rtl/rv_decode_pkg.sv - shared decode types: opcodes, arbiter states, legality check
package rv_decode_pkg;

    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        ALU_I  = 7'b0010011,
        ALU_R  = 7'b0110011,
        STORE  = 7'b0100011,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        BRANCH = 7'b1100011,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111
    } opcode_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HALTING  = 2'd1,
        HALTED   = 2'd2,
        DBG_EXEC = 2'd3
    } arb_state_e;

    // Only opcodes the immediate generator and control decoder understand.
    function automatic logic opcode_legal(input logic [31:0] instr);
        case (instr[6:0])
            LOAD, ALU_I, ALU_R, STORE, LUI, AUIPC, BRANCH, JAL, JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/inflight_counter.sv
// rtl/inflight_counter.sv - saturating up/down count of instructions issued but not retired
module inflight_counter #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             full
);

    assign zero = (count == '0);
    assign full = (count == CNT_W'(MAX_INFLIGHT));

    // Simultaneous inc and dec cancel; saturate at both ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/dbg_issue_arbiter.sv
// rtl/dbg_issue_arbiter.sv - decode issue slot shared between fetch and debugger injection
module dbg_issue_arbiter
    import rv_decode_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_instr,
    output logic             fetch_ready,
    input  logic             dbg_halt_req,
    input  logic             dbg_resume_req,
    output logic             dbg_halted,
    input  logic             dbg_instr_valid,
    input  logic [31:0]      dbg_instr,
    output logic             dbg_instr_ready,
    output logic             dbg_instr_done,
    output logic             dbg_instr_err,
    output logic             issue_valid,
    output logic [31:0]      issue_instr,
    output logic             issue_from_dbg,
    input  logic             issue_ready,
    input  logic             retire,
    output logic [CNT_W-1:0] inflight
);

    arb_state_e state, state_next;
    logic       slot_free;
    logic       cnt_zero, cnt_full;
    logic       fetch_load, dbg_load;
    logic       done_next, err_next;
    logic [CNT_W:0] occupancy;

    inflight_counter #(
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .CNT_W       (CNT_W)
    ) u_inflight (
        .clk  (clk),
        .rst  (rst),
        .inc  (issue_valid && issue_ready),
        .dec  (retire),
        .count(inflight),
        .zero (cnt_zero),
        .full (cnt_full)
    );

    assign slot_free  = !issue_valid || issue_ready;
    // The word already sitting in the slot will become in-flight too, so it counts.
    assign occupancy  = {1'b0, inflight} + (CNT_W+1)'(issue_valid);
    assign fetch_load = fetch_valid && fetch_ready;
    assign dbg_load   = dbg_instr_valid && dbg_instr_ready && opcode_legal(dbg_instr);
    assign dbg_halted = (state == HALTED) || (state == DBG_EXEC);

    always_comb begin
        state_next      = state;
        fetch_ready     = 1'b0;
        dbg_instr_ready = 1'b0;
        done_next       = 1'b0;
        err_next        = 1'b0;
        case (state)
            RUN: begin
                fetch_ready = slot_free && !dbg_halt_req && !cnt_full
                              && (occupancy < (CNT_W+1)'(MAX_INFLIGHT));
                if (dbg_halt_req) state_next = HALTING;
            end
            HALTING: begin
                if (!issue_valid && cnt_zero) state_next = HALTED;
            end
            HALTED: begin
                dbg_instr_ready = !issue_valid;
                if (dbg_instr_valid && !issue_valid) begin
                    if (opcode_legal(dbg_instr)) state_next = DBG_EXEC;
                    else                         err_next   = 1'b1;
                end else if (dbg_resume_req && !dbg_instr_valid) begin
                    state_next = RUN;
                end
            end
            DBG_EXEC: begin
                // The last in-flight instruction is the injected one.
                if (!issue_valid && retire && inflight == CNT_W'(1)) begin
                    done_next  = 1'b1;
                    state_next = HALTED;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            issue_valid    <= 1'b0;
            issue_instr    <= '0;
            issue_from_dbg <= 1'b0;
            dbg_instr_done <= 1'b0;
            dbg_instr_err  <= 1'b0;
        end else begin
            state          <= state_next;
            dbg_instr_done <= done_next;
            dbg_instr_err  <= err_next;
            if (fetch_load) begin
                issue_valid    <= 1'b1;
                issue_instr    <= fetch_instr;
                issue_from_dbg <= 1'b0;
            end else if (dbg_load) begin
                issue_valid    <= 1'b1;
                issue_instr    <= dbg_instr;
                issue_from_dbg <= 1'b1;
            end else if (issue_ready) begin
                issue_valid    <= 1'b0;
                issue_from_dbg <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dbg_issue_arbiter.md
Name: dbg_issue_arbiter

Overview:
- Sits in front of the decode stage, which holds the immediate generator, the register file read and the control decode.
- Owns the single decode-issue slot and shares it between two sources: the normal fetch stream and instructions injected by the external debugger.
- Sequences halt, drain, debug-execute and resume, tracking in-flight instructions so that debug instructions run only on an empty pipeline.
- Rejects injected instructions whose opcode the decode path does not support.

Parameters:
- MAX_INFLIGHT, 4, maximum instructions accepted by decode and not yet retired; fetch is throttled at this limit.
- CNT_W, $clog2(MAX_INFLIGHT+1), width of the in-flight counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch instruction valid.
- fetch_instr  in  32  fetched instruction word.
- fetch_ready  out  1  arbiter accepts the fetch word this cycle.
- dbg_halt_req  in  1  level; request core halt.
- dbg_resume_req  in  1  level; request resume from halt.
- dbg_halted  out  1  core halted and the debugger owns the issue slot.
- dbg_instr_valid  in  1  injected instruction valid.
- dbg_instr  in  32  injected instruction word.
- dbg_instr_ready  out  1  arbiter accepts the injected word this cycle.
- dbg_instr_done  out  1  one-cycle pulse: the injected instruction retired.
- dbg_instr_err  out  1  one-cycle pulse: the injected opcode was rejected.
- issue_valid  out  1  registered instruction presented to decode.
- issue_instr  out  32  registered instruction word.
- issue_from_dbg  out  1  the slot holds an injected instruction.
- issue_ready  in  1  decode accepts the slot this cycle.
- retire  in  1  one instruction retired at writeback.
- inflight  out  CNT_W  current in-flight count.

Behaviour:

Reset:
- State RUN.
- issue_valid, issue_instr, issue_from_dbg, dbg_halted, dbg_instr_done, dbg_instr_err and inflight all reset to 0.
- rst asserted in any state, including DBG_EXEC, aborts the operation; no done or err pulse is produced.

Issue slot:
- The slot is a single register. slot_free = !issue_valid || issue_ready.
- The slot loads on an accepted source word. issue_valid clears when issue_ready is high and nothing loads.
- Contents are held stable while issue_valid && !issue_ready.
- Latency: a word accepted in cycle N appears on issue_valid in cycle N+1.

In-flight counter:
- +1 on issue_valid && issue_ready; -1 on retire.
- Both in the same cycle: unchanged.
- retire while the count is 0 is ignored (count stays 0).
- The count never exceeds MAX_INFLIGHT.

State RUN:
- fetch_ready = slot_free && !dbg_halt_req && (inflight + issue_valid < MAX_INFLIGHT).
- dbg_instr_ready = 0.
- dbg_halt_req = 1 moves to HALTING next cycle; fetch is blocked combinationally in that same cycle.

State HALTING:
- fetch_ready = 0 and dbg_instr_ready = 0.
- Moves to HALTED when !issue_valid && inflight == 0.
- dbg_resume_req is ignored; the halt always completes.

State HALTED:
- dbg_halted = 1.
- dbg_instr_ready = 1 while the slot is empty.
- On an accepted dbg_instr:
  - Legal opcode: load the slot with issue_from_dbg = 1 and move to DBG_EXEC.
  - Illegal opcode: the slot is untouched, dbg_instr_err pulses the next cycle, and the state stays HALTED.
- Legal opcodes: LOAD, ALU_I, ALU_R (0110011), STORE, LUI, AUIPC, BRANCH, JAL, JALR.
- dbg_resume_req = 1 with no dbg_instr_valid moves to RUN next cycle. If both are high in the same cycle, the instruction wins and resume is ignored that cycle.
- dbg_halt_req is ignored.

State DBG_EXEC:
- dbg_halted = 1; fetch_ready = 0 and dbg_instr_ready = 0.
- When the slot is empty and the counter reaches 0 via retire, dbg_instr_done pulses for one cycle and the state returns to HALTED.
- dbg_halt_req and dbg_resume_req are ignored.

Other:
- dbg_halted deasserts in the first RUN cycle.
- issue_from_dbg is 0 for fetch loads.
- Branch or jump redirect and flush are outside this block; fetch handles them.

Decomposition:
- Package rv_decode_pkg holds:
  - the opcode enum (LOAD, ALU_I, ALU_R, STORE, LUI, AUIPC, BRANCH, JAL, JALR), shared with the immediate generator and the control decoder;
  - the arbiter state enum (RUN, HALTING, HALTED, DBG_EXEC);
  - an opcode_legal function.
- One sub-module, inflight_counter: saturating up/down counter parameterised by MAX_INFLIGHT, exposing the count, a zero flag and a full flag.

Test Plan:
1. Basic fetch: after reset, fetch_valid = 1 with fetch_instr = 32'h00500093 and issue_ready = 1 -> issue_valid = 1 with issue_instr = 32'h00500093 the next cycle; inflight = 1 after the accept; retire brings it to 0.
2. Throttle: with retire held at 0, feed fetch continuously -> fetch_ready drops once inflight + issue_valid = 4; one retire pulse re-admits exactly one word.
3. Halt and drain: assert dbg_halt_req with 2 in flight -> fetch_ready = 0 the same cycle; dbg_halted rises one cycle after the second retire brings inflight to 0.
4. Debug execute: while halted, inject 32'h00A00113 (ADDI) -> issue_from_dbg = 1 the next cycle; retire -> dbg_instr_done pulses for exactly one cycle; state is HALTED again and dbg_instr_ready = 1.
5. Illegal opcode: while halted, inject 32'h0000007F -> dbg_instr_err pulses once, issue_valid stays 0, inflight stays 0.
6. Simultaneous and reset cases:
   - In HALTED, dbg_instr_valid and dbg_resume_req high together -> the instruction is taken and the state stays halted.
   - rst pulse mid DBG_EXEC -> all outputs are 0 and the state is RUN the next cycle, with no done pulse.
